// File: rtl/arb4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter.
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index
//   state_e : arbiter FSM states (IDLE = 1'b0, GRANT = 1'b1)
//   rr_pick : combinational rotate-and-find-first priority search
package arb4_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Returns the first set request searching ptr+1, ptr+2, ptr+3, ptr (mod N_REQ).
  // The result is meaningless when req is all zero; callers gate on |req.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W:0]     base;
    logic [IDX_W-1:0]   off;
    dbl  = {req, req};
    base = {1'b0, ptr} + (IDX_W + 1)'(1);
    // rot[0] is the requester immediately after ptr
    rot  = dbl[base +: N_REQ];
    off  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
    return ptr + IDX_W'(1) + off;
  endfunction

endpackage

// File: rtl/idx_dec2to4.sv
// Binary index to one-hot decoder with enable.
//   idx    : 2-bit index
//   en     : when low the output is all zero
//   onehot : decoded 4-bit one-hot value
module idx_dec2to4
  import arb4_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Four-requester round-robin arbiter with bounded tenure.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   req       : level-sensitive requests, bit n = requester n
//   gnt       : one-hot grant (zero when no grant is held)
//   gnt_idx   : index of the current or most recent grantee
//   gnt_valid : high while a grant is held
//   preempt   : one-cycle pulse in the first idle cycle after a hold timeout
// Every tenure is followed by at least one idle cycle. A grant lasts at most
// MAX_HOLD cycles (legal range 2..255).
module rr_arb4_ctrl
  import arb4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] pick;

  assign pick = rr_pick(req, ptr_q);

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = GRANT;
          gnt_idx_d  = pick;
          ptr_d      = pick;
          valid_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        // A dropped request wins over a coincident timeout: no preempt then.
        if (!req[gnt_idx_q]) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          preempt_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      ptr_q      <= '1;  // requester 0 searched first after reset
      valid_q    <= 1'b0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      valid_q    <= valid_d;
      preempt_q  <= preempt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  idx_dec2to4 u_dec (
    .idx    (gnt_idx_q),
    .en     (valid_q),
    .onehot (gnt)
  );

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Bench for rr_arb4_ctrl: one instance with MAX_HOLD=8 (a), one with MAX_HOLD=2 (b).
// A behavioural model tracks owner / tenure length / last grantee per instance
// and every output is compared on each falling edge.
module tb_rr_arb4_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       valid_a, valid_b;
  logic       pre_a, pre_b;

  always #5 clk = ~clk;

  rr_arb4_ctrl #(.MAX_HOLD(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req       (req_a),
    .gnt       (gnt_a),
    .gnt_idx   (idx_a),
    .gnt_valid (valid_a),
    .preempt   (pre_a)
  );

  rr_arb4_ctrl #(.MAX_HOLD(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req       (req_b),
    .gnt       (gnt_b),
    .gnt_idx   (idx_b),
    .gnt_valid (valid_b),
    .preempt   (pre_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy[2];
  int m_owner[2];
  int m_held[2];
  int m_last[2];
  bit m_pre[2];

  task automatic model_step(input int i, input logic [3:0] r, input int maxh);
    bit busy  = m_busy[i];
    int owner = m_owner[i];
    int held  = m_held[i];
    int last  = m_last[i];
    bit pre   = 1'b0;
    if (busy) begin
      if (!r[owner]) busy = 1'b0;
      else if (held == maxh) begin
        busy = 1'b0;
        pre  = 1'b1;
      end else held++;
    end else if (r != 4'b0000) begin
      bit found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last + k) % 4;
        if (!found && r[c]) begin
          found = 1'b1;
          owner = c;
          last  = c;
          busy  = 1'b1;
          held  = 1;
        end
      end
    end
    m_busy[i]  <= busy;
    m_owner[i] <= owner;
    m_held[i]  <= held;
    m_last[i]  <= last;
    m_pre[i]   <= pre;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  <= 1'b0;
        m_owner[i] <= 0;
        m_held[i]  <= 0;
        m_last[i]  <= 3;
        m_pre[i]   <= 1'b0;
      end
    end else begin
      model_step(0, req_a, 8);
      model_step(1, req_b, 2);
    end
  end

  // ---------------- per-cycle checks ----------------
  task automatic check_cycle(input int i, input logic [3:0] g, input logic [1:0] ix,
                             input logic v, input logic p, input int maxh,
                             input int run, output int run_n);
    logic [3:0] eg;
    string      s;
    s  = (i == 0) ? "a" : "b";
    eg = 4'b0000;
    if (m_busy[i]) eg[m_owner[i]] = 1'b1;
    check({s, ".gnt"}, 8'(g), 8'(eg));
    check({s, ".gnt_valid"}, 8'(v), 8'(m_busy[i]));
    check({s, ".preempt"}, 8'(p), 8'(m_pre[i]));
    check({s, ".gnt_idx"}, 8'(ix), 8'(m_owner[i]));
    check({s, ".onehot0"}, 8'($onehot0(g)), 8'd1);
    if (v) check({s, ".decode"}, 8'(g), 8'(4'b0001 << ix));
    run_n = v ? run + 1 : 0;
    if (v) check({s, ".tenure_max"}, 8'(run_n <= maxh), 8'd1);
  endtask

  int run_a = 0, run_b = 0;
  bit prev_valid_a = 1'b0;
  int starts[$];

  always @(negedge clk) begin
    int ra, rb;
    check_cycle(0, gnt_a, idx_a, valid_a, pre_a, 8, run_a, ra);
    check_cycle(1, gnt_b, idx_b, valid_b, pre_b, 2, run_b, rb);
    run_a = ra;
    run_b = rb;
    if (valid_a && !prev_valid_a) starts.push_back(int'(idx_a));
    prev_valid_a = valid_a;
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       v;
    logic       p;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic v,
                     input logic p, input logic [1:0] ix, input int n);
    vec_t e;
    e.req = r; e.gnt = g; e.v = v; e.p = p; e.idx = ix;
    repeat (n) tbl.push_back(e);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (valid_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 8'(valid_a), 8'd0);
  endtask

  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // req=0100 x3 then idle; ptr ends at 2 so 1111 picks 3
    add(4'b0100, 4'b0100, 1, 0, 2'd2, 3);
    add(4'b0000, 4'b0000, 0, 0, 2'd2, 2);
    add(4'b1111, 4'b1000, 1, 0, 2'd3, 1);
    add(4'b0000, 4'b0000, 0, 0, 2'd3, 1);
    // req[3] drops in the last allowed cycle: voluntary
    add(4'b1000, 4'b1000, 1, 0, 2'd3, 8);
    add(4'b0000, 4'b0000, 0, 0, 2'd3, 1);
    // req[3] held past the limit: timeout with preempt
    add(4'b1000, 4'b1000, 1, 0, 2'd3, 8);
    add(4'b1000, 4'b0000, 0, 1, 2'd3, 1);
    add(4'b0000, 4'b0000, 0, 0, 2'd3, 1);
    // other bits changing mid-grant are ignored
    add(4'b0001, 4'b0001, 1, 0, 2'd0, 1);
    add(4'b0011, 4'b0001, 1, 0, 2'd0, 1);
    add(4'b1110, 4'b0000, 0, 0, 2'd0, 1);
    add(4'b0010, 4'b0010, 1, 0, 2'd1, 1);
    add(4'b0000, 4'b0000, 0, 0, 2'd1, 1);
    // preempted requester 0 yields to requester 1
    add(4'b0001, 4'b0001, 1, 0, 2'd0, 8);
    add(4'b0011, 4'b0000, 0, 1, 2'd0, 1);
    add(4'b0011, 4'b0010, 1, 0, 2'd1, 1);
    add(4'b0000, 4'b0000, 0, 0, 2'd1, 1);

    rst = 1'b0; req_a = 4'b0000; req_b = 4'b0000;
    #2 rst = 1'b1;
    #1;
    check("rst.gnt_a", 8'(gnt_a), 8'd0);
    check("rst.valid_a", 8'(valid_a), 8'd0);
    check("rst.pre_a", 8'(pre_a), 8'd0);
    check("rst.idx_a", 8'(idx_a), 8'd0);
    check("rst.gnt_b", 8'(gnt_b), 8'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // all requesting: order 0,1,2,3,0
    starts.delete();
    req_a = 4'b1111;
    repeat (40) @(negedge clk);
    req_a = 4'b0000;
    wait_idle_a();
    for (int k = 0; k < 5; k++)
      check($sformatf("order%0d", k), (k < starts.size()) ? 8'(starts[k]) : 8'hff,
            8'(exp_ord[k]));

    foreach (tbl[k]) begin
      @(negedge clk);
      req_a = tbl[k].req;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d.gnt", k), 8'(gnt_a), 8'(tbl[k].gnt));
      check($sformatf("tbl%0d.valid", k), 8'(valid_a), 8'(tbl[k].v));
      check($sformatf("tbl%0d.preempt", k), 8'(pre_a), 8'(tbl[k].p));
      check($sformatf("tbl%0d.idx", k), 8'(gnt_idx_of_a()), 8'(tbl[k].idx));
    end
    @(negedge clk);
    req_a = 4'b0000;

    // random traffic against the model
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req_a = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req_b = 4'($urandom);
    end

    // reset in the middle of a grant to requester 2
    @(negedge clk);
    req_a = 4'b0000; req_b = 4'b0000; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_a = 4'b0101;
    @(posedge clk); #1;
    check("r30.first", 8'(gnt_a), 8'h01);
    @(negedge clk); req_a = 4'b0000;
    @(posedge clk); #1;
    check("r30.release", 8'(gnt_a), 8'h00);
    @(negedge clk); req_a = 4'b0101;
    @(posedge clk); #1;
    check("r30.grant2", 8'(gnt_a), 8'h04);
    check("r30.idx2", 8'(idx_a), 8'd2);
    #1 rst = 1'b1;
    #1;
    check("r30.rst_gnt", 8'(gnt_a), 8'h00);
    check("r30.rst_valid", 8'(valid_a), 8'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("r30.after_rst", 8'(gnt_a), 8'h01);
    check("r30.after_idx", 8'(idx_a), 8'd0);
    @(negedge clk); req_a = 4'b0000;

    // MAX_HOLD=2 with constant req: 2 grant cycles, 1 idle with preempt
    @(negedge clk); req_b = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      check($sformatf("r28.gnt%0d", k), 8'(gnt_b), (k % 3 == 2) ? 8'h00 : 8'h01);
      check($sformatf("r28.pre%0d", k), 8'(pre_b), (k % 3 == 2) ? 8'd1 : 8'd0);
    end
    @(negedge clk); req_b = 4'b0000;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [1:0] gnt_idx_of_a();
    return idx_a;
  endfunction

endmodule

// File: doc/rr_arb4_ctrl.md
RR_ARB4_CTRL -- requirements
Module: rr_arb4_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per tenure; legal range 2..255.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester request; bit n = requester n; level-sensitive.
REQ-005 gnt  output  4  one-hot grant, the decoded form of gnt_idx when gnt_valid=1, else 4'b0000.
REQ-006 gnt_idx  output  2  binary index of the current or last grantee.
REQ-007 gnt_valid  output  1  high while a grant is held.
REQ-008 preempt  output  1  one-cycle pulse on forced release by hold timeout.

Function
REQ-009 The FSM SHALL have exactly two states, IDLE and GRANT, and all outputs SHALL be registered.
REQ-010 In IDLE with req!=0, the next edge SHALL enter GRANT, with gnt_idx = first set req bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4); req-to-gnt latency is 1 cycle.
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0 and gnt_valid=0.
REQ-012 ptr SHALL be a 2-bit last-grantee register, loaded with gnt_idx on every GRANT entry, wrapping 3->0.
REQ-013 In GRANT, hold_cnt (8-bit) SHALL clear on entry and increment each cycle the grant persists.
REQ-014 In GRANT, the next edge SHALL return to IDLE (gnt=0) when req[gnt_idx]=0 (voluntary release) or hold_cnt==MAX_HOLD-1 (timeout).
REQ-015 A timeout release SHALL assert preempt for exactly the one cycle in which gnt first reads 0; a voluntary release SHALL not assert preempt.
REQ-016 When timeout and req drop occur in the same cycle, the release SHALL be treated as voluntary (preempt=0).
REQ-017 Every tenure SHALL be followed by at least one IDLE cycle (gnt=0), so no back-to-back grants occur.
REQ-018 A grant SHALL never exceed MAX_HOLD cycles; a preempted requester still asserting req SHALL re-arbitrate at lowest priority.
REQ-019 Changes to req bits other than req[gnt_idx] during GRANT SHALL have no effect until the next IDLE.
REQ-020 gnt SHALL be one-hot or zero in every cycle, and gnt_idx SHALL hold its value through IDLE.

Reset
REQ-021 While rst=1, the block SHALL set, independent of clk: state=IDLE, gnt=0, gnt_valid=0, preempt=0, gnt_idx=2'b00, hold_cnt=0, ptr=2'b11 (req0 highest priority first).
REQ-022 Reset asserted mid-grant SHALL drop gnt within the same cycle; the first arbitration after deassertion SHALL follow REQ-021 priority.

Structure
REQ-023 Package arb4_pkg SHALL hold the state encoding (IDLE=1'b0, GRANT=1'b1), the requester count N_REQ=4 and the index width IDX_W=2.
REQ-024 gnt SHALL be produced by one sub-module, idx_dec2to4 (2-bit index, enable -> 4-bit one-hot), instantiated once and fed from registered gnt_idx/gnt_valid.
REQ-025 The priority search SHALL be a combinational rotate-and-find-first; implementation is 120-400 RTL lines.

Verification
REQ-026 Reset release, then req=4'b1111 held: grantee order SHALL be 0,1,2,3,0 with one IDLE cycle between tenures and preempt on each tenure (MAX_HOLD=8, 8 cycles each).
REQ-027 req=4'b0100 for 3 cycles then 0: gnt=4'b0100 from cycle 2 for 3 cycles, then gnt=0, preempt=0, ptr=2.
REQ-028 MAX_HOLD=2, req=4'b0001 constant: gnt SHALL alternate 2 cycles 4'b0001, 1 cycle 4'b0000, with preempt high in each zero cycle.
REQ-029 req[3] drops in the cycle hold_cnt==MAX_HOLD-1: release, preempt=0.
REQ-030 rst pulsed during a grant to requester 2 with req=4'b0101: gnt=0 immediately, and the first grant after reset SHALL go to requester 0.
REQ-031 Every test SHALL check each cycle that gnt is one-hot or zero, gnt==decode(gnt_idx) when gnt_valid=1, and no tenure exceeds MAX_HOLD.
